// File: rtl/global_variables.sv
// global_variables: machine-wide constants shared by the pipeline back end.
//   XLEN      - datapath width
//   ROB_DEPTH - default number of reorder buffer entries
package global_variables;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned ROB_DEPTH = 16;

endpackage

// File: rtl/structures.sv
// structures: shared record types for the pipeline back end.
//   rob_entry_t - one reorder buffer entry (result value, destinations, status bits)
package structures;

   import global_variables::*;

   typedef struct packed {
      logic [XLEN-1:0] value;
      logic [5:0]      arn;
      logic [5:0]      rrn;
      logic            done;
      logic            tag;
      logic            valid;
   } rob_entry_t;

endpackage

// File: rtl/rob_match.sv
// rob_match: combinational CAM over the reorder buffer entries for one CDB port.
// Ports:
//   entries   in  - full entry array
//   cdb_valid in  - broadcast valid
//   cdb_rrn   in  - renamed register being broadcast
//   hit       out - one bit per entry: valid, not yet done, rrn matches
module rob_match
   import structures::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  rob_entry_t       entries [DEPTH],
   input  logic             cdb_valid,
   input  logic [5:0]       cdb_rrn,
   output logic [DEPTH-1:0] hit
);

   // Fields the CAM does not look at; folded here so they are consumed.
   logic unused_fields;

   always_comb begin
      hit           = '0;
      unused_fields = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         hit[i] = cdb_valid && entries[i].valid && !entries[i].done &&
                  (entries[i].rrn == cdb_rrn);
         unused_fields = unused_fields ^ (^entries[i].value) ^ (^entries[i].arn) ^
                         entries[i].tag;
      end
   end

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer. Two renamed instructions enter per cycle,
// results are captured from two CDB ports, up to two completed instructions retire per
// cycle in program order. Tagged (speculative) entries wait for clear_tag or are squashed
// by delete_tag.
// Optional feature: define ROB_CDB_BYPASS_EN to let a CDB result retire the head
// candidate at the same edge that would set done (one cycle less commit latency).
// Ports:
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   clear_tag, delete_tag - branch resolved correct / mispredicted
//   dispatch_*            - two dispatch slots in, ready and assigned indices out
//   cdb_*                 - two result broadcast ports
//   commit_*              - registered retire outputs, one per slot
//   count                 - occupied entries
module reorder_buffer
   import structures::*;
#(
   parameter int unsigned XLEN  = global_variables::XLEN,
   parameter int unsigned DEPTH = global_variables::ROB_DEPTH
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     clear_tag,
   input  logic                     delete_tag,
   input  logic                     dispatch_valid   [2],
   input  logic [5:0]               dispatch_arn     [2],
   input  logic [5:0]               dispatch_rrn     [2],
   input  logic                     dispatch_tag     [2],
   output logic                     dispatch_ready,
   output logic [$clog2(DEPTH)-1:0] dispatch_idx     [2],
   input  logic                     cdb_valid        [2],
   input  logic [5:0]               cdb_rrn          [2],
   input  logic [XLEN-1:0]          cdb_result       [2],
   output logic                     commit_reg_write [2],
   output logic [5:0]               commit_arn       [2],
   output logic [5:0]               commit_rrn       [2],
   output logic [XLEN-1:0]          commit_result    [2],
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned IW = $clog2(DEPTH);

   typedef logic [IW-1:0] idx_t;
   typedef logic [IW:0]   cnt_t;

   rob_entry_t       entries_q [DEPTH];
   rob_entry_t       entries_d [DEPTH];
   idx_t             head_q, head_d, tail_q, tail_d;
   cnt_t             count_q, count_d;
   logic [DEPTH-1:0] hit0, hit1;

   idx_t             head_p1, tail_p1;
   idx_t             cand_idx     [2];
   rob_entry_t       cand         [2];
   logic             retire       [2];
   logic [XLEN-1:0]  retire_value [2];
   logic             accept;
   cnt_t             n_disp, n_retired, n_tagged;

   rob_match #(.DEPTH(DEPTH)) u_match0 (
      .entries   (entries_q),
      .cdb_valid (cdb_valid[0]),
      .cdb_rrn   (cdb_rrn[0]),
      .hit       (hit0)
   );

   rob_match #(.DEPTH(DEPTH)) u_match1 (
      .entries   (entries_q),
      .cdb_valid (cdb_valid[1]),
      .cdb_rrn   (cdb_rrn[1]),
      .hit       (hit1)
   );

   assign head_p1         = head_q + idx_t'(1);
   assign tail_p1         = tail_q + idx_t'(1);
   assign dispatch_ready  = (count_q <= cnt_t'(DEPTH - 2)) && !delete_tag;
   assign dispatch_idx[0] = tail_q;
   assign dispatch_idx[1] = tail_p1;
   assign count           = count_q;
   assign accept          = dispatch_ready && dispatch_valid[0];

   // Retire selection uses the pre-edge tag, so clear_tag only helps from the next cycle.
   always_comb begin
      cand_idx[0] = head_q;
      cand_idx[1] = head_p1;
      for (int k = 0; k < 2; k++) begin
         cand[k]         = entries_q[cand_idx[k]];
         retire[k]       = cand[k].valid && cand[k].done && !cand[k].tag;
         retire_value[k] = cand[k].value;
`ifdef ROB_CDB_BYPASS_EN
         if (cand[k].valid && !cand[k].done && !cand[k].tag &&
             (hit0[cand_idx[k]] || hit1[cand_idx[k]])) begin
            retire[k]       = 1'b1;
            retire_value[k] = hit1[cand_idx[k]] ? cdb_result[1] : cdb_result[0];
         end
`endif
      end
      retire[1] = retire[1] && retire[0];
   end

   always_comb begin
      n_tagged = '0;
      for (int i = 0; i < DEPTH; i++) begin
         n_tagged = n_tagged + cnt_t'(entries_q[i].valid & entries_q[i].tag);
      end
      n_retired = cnt_t'(retire[0]) + cnt_t'(retire[1]);
      n_disp    = '0;
      if (accept) begin
         n_disp = dispatch_valid[1] ? cnt_t'(2) : cnt_t'(1);
      end
   end

   always_comb begin
      entries_d = entries_q;
      head_d    = head_q + idx_t'(n_retired);
      tail_d    = tail_q;
      count_d   = count_q + n_disp - n_retired;

      // Writeback; port 1 has priority when both ports hit the same entry.
      for (int i = 0; i < DEPTH; i++) begin
         if (hit1[i]) begin
            entries_d[i].done  = 1'b1;
            entries_d[i].value = cdb_result[1];
         end else if (hit0[i]) begin
            entries_d[i].done  = 1'b1;
            entries_d[i].value = cdb_result[0];
         end
      end

      for (int k = 0; k < 2; k++) begin
         if (retire[k]) begin
            entries_d[cand_idx[k]] = '0;
         end
      end

      // Tagged entries are the youngest contiguous run, so tail backs up by their count.
      if (delete_tag) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (entries_q[i].valid && entries_q[i].tag) begin
               entries_d[i] = '0;
            end
         end
         tail_d  = tail_q - idx_t'(n_tagged);
         count_d = count_q - n_retired - n_tagged;
      end else if (clear_tag) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_d[i].tag = 1'b0;
         end
      end

      if (accept) begin
         entries_d[tail_q].value = '0;
         entries_d[tail_q].arn   = dispatch_arn[0];
         entries_d[tail_q].rrn   = dispatch_rrn[0];
         entries_d[tail_q].done  = 1'b0;
         entries_d[tail_q].tag   = dispatch_tag[0];
         entries_d[tail_q].valid = 1'b1;
         if (dispatch_valid[1]) begin
            entries_d[tail_p1].value = '0;
            entries_d[tail_p1].arn   = dispatch_arn[1];
            entries_d[tail_p1].rrn   = dispatch_rrn[1];
            entries_d[tail_p1].done  = 1'b0;
            entries_d[tail_p1].tag   = dispatch_tag[1];
            entries_d[tail_p1].valid = 1'b1;
         end
         tail_d = tail_q + idx_t'(n_disp);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int k = 0; k < 2; k++) begin
            commit_reg_write[k] <= 1'b0;
            commit_arn[k]       <= '0;
            commit_rrn[k]       <= '0;
            commit_result[k]    <= '0;
         end
      end else begin
         entries_q <= entries_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         for (int k = 0; k < 2; k++) begin
            commit_reg_write[k] <= retire[k] && (cand[k].arn != 6'd0);
            if (retire[k]) begin
               commit_arn[k]    <= cand[k].arn;
               commit_rrn[k]    <= cand[k].rrn;
               commit_result[k] <= retire_value[k];
            end
         end
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned XLEN  = 32;

   logic             clock = 1'b0;
   logic             reset;
   logic             clear_tag;
   logic             delete_tag;
   logic             dispatch_valid   [2];
   logic [5:0]       dispatch_arn     [2];
   logic [5:0]       dispatch_rrn     [2];
   logic             dispatch_tag     [2];
   logic             dispatch_ready;
   logic [3:0]       dispatch_idx     [2];
   logic             cdb_valid        [2];
   logic [5:0]       cdb_rrn          [2];
   logic [XLEN-1:0]  cdb_result       [2];
   logic             commit_reg_write [2];
   logic [5:0]       commit_arn       [2];
   logic [5:0]       commit_rrn       [2];
   logic [XLEN-1:0]  commit_result    [2];
   logic [4:0]       count;

   reorder_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clock            (clock),
      .reset            (reset),
      .clear_tag        (clear_tag),
      .delete_tag       (delete_tag),
      .dispatch_valid   (dispatch_valid),
      .dispatch_arn     (dispatch_arn),
      .dispatch_rrn     (dispatch_rrn),
      .dispatch_tag     (dispatch_tag),
      .dispatch_ready   (dispatch_ready),
      .dispatch_idx     (dispatch_idx),
      .cdb_valid        (cdb_valid),
      .cdb_rrn          (cdb_rrn),
      .cdb_result       (cdb_result),
      .commit_reg_write (commit_reg_write),
      .commit_arn       (commit_arn),
      .commit_rrn       (commit_rrn),
      .commit_result    (commit_result),
      .count            (count)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: program-ordered queue of in-flight instructions.
   typedef struct {
      logic [5:0]  arn;
      logic [5:0]  rrn;
      logic        tag;
      logic        done;
      logic [31:0] value;
   } ment_t;

   ment_t       q[$];
   int          head = 0;
   bit          model_valid = 0;
   logic        exp_wr  [2];
   logic [5:0]  exp_arn [2];
   logic [5:0]  exp_rrn [2];
   logic [31:0] exp_res [2];

   task automatic model_edge();
      int    nret;
      bit    rdy;
      ment_t e;
      if (reset) begin
         q.delete();
         head = 0;
         for (int k = 0; k < 2; k++) begin
            exp_wr[k] = 0; exp_arn[k] = 0; exp_rrn[k] = 0; exp_res[k] = 0;
         end
         model_valid = 1;
         return;
      end
      rdy  = (q.size() <= DEPTH - 2) && !delete_tag;
      nret = 0;
      for (int k = 0; k < 2; k++) begin
         if (nret == k && q.size() > k && q[k].done && !q[k].tag) nret++;
      end
      for (int k = 0; k < 2; k++) begin
         if (k < nret) begin
            exp_wr[k]  = (q[k].arn != 0);
            exp_arn[k] = q[k].arn;
            exp_rrn[k] = q[k].rrn;
            exp_res[k] = q[k].value;
         end else begin
            exp_wr[k] = 0;
         end
      end
      for (int i = 0; i < q.size(); i++) begin
         e = q[i];
         if (!e.done) begin
            if (cdb_valid[1] && cdb_rrn[1] == e.rrn) begin
               e.done = 1; e.value = cdb_result[1];
            end else if (cdb_valid[0] && cdb_rrn[0] == e.rrn) begin
               e.done = 1; e.value = cdb_result[0];
            end
         end
         q[i] = e;
      end
      for (int k = 0; k < nret; k++) begin
         q.delete(0);
         head = (head + 1) % DEPTH;
      end
      if (delete_tag) begin
         while (q.size() > 0 && q[q.size()-1].tag) q.delete(q.size() - 1);
      end else if (clear_tag) begin
         for (int i = 0; i < q.size(); i++) begin
            e = q[i]; e.tag = 0; q[i] = e;
         end
      end
      if (rdy && dispatch_valid[0]) begin
         for (int k = 0; k < 2; k++) begin
            if (dispatch_valid[k]) begin
               e.arn = dispatch_arn[k]; e.rrn = dispatch_rrn[k]; e.tag = dispatch_tag[k];
               e.done = 0; e.value = 0;
               q.push_back(e);
            end
         end
      end
   endtask

   // One clock: called at a negedge with inputs already driven, returns at the next negedge.
   task automatic step();
      #1;
      if (model_valid) begin
         check_val("ready", dispatch_ready, (q.size() <= DEPTH - 2) && !delete_tag);
         check_val("idx0", dispatch_idx[0], (head + q.size()) % DEPTH);
         check_val("idx1", dispatch_idx[1], (head + q.size() + 1) % DEPTH);
      end
      @(posedge clock);
      model_edge();
      #1;
      check_val("count", count, q.size());
      for (int k = 0; k < 2; k++) begin
         check_val($sformatf("wr%0d", k), commit_reg_write[k], exp_wr[k]);
         check_val($sformatf("arn%0d", k), commit_arn[k], exp_arn[k]);
         check_val($sformatf("rrn%0d", k), commit_rrn[k], exp_rrn[k]);
         check_val($sformatf("res%0d", k), commit_result[k], exp_res[k]);
      end
      @(negedge clock);
   endtask

   task automatic idle_inputs();
      reset = 0; clear_tag = 0; delete_tag = 0;
      for (int k = 0; k < 2; k++) begin
         dispatch_valid[k] = 0; dispatch_arn[k] = 0; dispatch_rrn[k] = 6'd32;
         dispatch_tag[k] = 0; cdb_valid[k] = 0; cdb_rrn[k] = 0; cdb_result[k] = 0;
      end
   endtask

   task automatic set_disp(input int k, input logic [5:0] arn, input logic [5:0] rrn,
                           input logic tag);
      dispatch_valid[k] = 1; dispatch_arn[k] = arn; dispatch_rrn[k] = rrn;
      dispatch_tag[k] = tag;
   endtask

   task automatic set_cdb(input int k, input logic [5:0] rrn, input logic [31:0] val);
      cdb_valid[k] = 1; cdb_rrn[k] = rrn; cdb_result[k] = val;
   endtask

   function automatic logic [5:0] free_rrn(input logic [5:0] avoid);
      logic [5:0] r;
      bit         used;
      for (int tries = 0; tries < 1000; tries++) begin
         r = 6'(32 + $urandom_range(31));
         used = (r == avoid);
         foreach (q[i]) if (q[i].rrn == r) used = 1;
         if (!used) return r;
      end
      return 6'd63;
   endfunction

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      step();
      idle_inputs();
   endtask

   task automatic rand_inputs();
      bit         have_tag;
      logic       t0;
      logic [5:0] r0;
      idle_inputs();
      reset      = ($urandom_range(199) == 0);
      delete_tag = ($urandom_range(15) == 0);
      clear_tag  = ($urandom_range(15) == 0);
      have_tag   = 0;
      foreach (q[i]) if (q[i].tag) have_tag = 1;
      if ($urandom_range(3) != 0) begin
         t0 = clear_tag ? 1'b0 : (have_tag ? 1'b1 : ($urandom_range(3) == 0));
         r0 = free_rrn(6'd0);
         set_disp(0, 6'($urandom_range(63)), r0, t0);
         if ($urandom_range(1) == 1) begin
            set_disp(1, 6'($urandom_range(63)), free_rrn(r0),
                     clear_tag ? 1'b0 : (t0 | ($urandom_range(3) == 0)));
         end
      end
      for (int k = 0; k < 2; k++) begin
         if ($urandom_range(1) == 1) begin
            if (q.size() > 0 && $urandom_range(3) != 0)
               set_cdb(k, q[$urandom_range(q.size() - 1)].rrn, $urandom);
            else
               set_cdb(k, 6'($urandom_range(63)), $urandom);
         end
      end
   endtask

   initial begin
      logic [5:0] r0;
      int         n;
      idle_inputs();
      reset = 1;
      @(negedge clock);

      // Reset held two cycles.
      step();
      step();
      idle_inputs();
      step();
      check_val("rst_count", count, 0);
      check_val("rst_ready", dispatch_ready, 1);
      check_val("rst_wr0", commit_reg_write[0], 0);

      // Out-of-order completion, in-order retirement.
      set_disp(0, 6'd5, 6'd32, 0);
      set_disp(1, 6'd6, 6'd33, 0);
      step();
      idle_inputs(); step();
      set_cdb(0, 6'd33, 32'hBEEF); step();
      idle_inputs(); step();
      set_cdb(1, 6'd32, 32'h1234); step();
      check_val("ooo_early_wr0", commit_reg_write[0], 0);
      idle_inputs(); step();
      check_val("ooo_wr0", commit_reg_write[0], 1);
      check_val("ooo_wr1", commit_reg_write[1], 1);
      check_val("ooo_arn0", commit_arn[0], 5);
      check_val("ooo_res0", commit_result[0], 32'h1234);
      check_val("ooo_arn1", commit_arn[1], 6);
      check_val("ooo_res1", commit_result[1], 32'hBEEF);
      step();

      // Fill to DEPTH, drain two, then stream across the wrap.
      do_reset();
      for (int s = 0; s < 8; s++) begin
         idle_inputs();
         set_disp(0, 6'(s + 1), 6'(32 + 2 * s), 0);
         set_disp(1, 6'(s + 9), 6'(33 + 2 * s), 0);
         step();
      end
      idle_inputs();
      check_val("full_count", count, 16);
      check_val("full_ready", dispatch_ready, 0);
      set_cdb(0, 6'd32, 32'h11); step();
      idle_inputs(); step();
      check_val("full_m1_count", count, 15);
      check_val("full_m1_ready", dispatch_ready, 0);
      set_cdb(0, 6'd33, 32'h22); step();
      idle_inputs(); step();
      check_val("full_m2_ready", dispatch_ready, 1);
      for (int s = 0; s < 20; s++) begin
         idle_inputs();
         n = 0;
         for (int i = 0; i < q.size() && n < 2; i++) begin
            if (!q[i].done) begin
               set_cdb(n, q[i].rrn, $urandom);
               n++;
            end
         end
         if (q.size() <= DEPTH - 2) begin
            r0 = free_rrn(6'd0);
            set_disp(0, 6'(s + 1), r0, 0);
            set_disp(1, 6'(s + 2), free_rrn(r0), 0);
         end
         step();
      end

      // Squash of tagged entries.
      do_reset();
      set_disp(0, 6'd1, 6'd40, 0); step();
      idle_inputs();
      set_disp(0, 6'd2, 6'd41, 1);
      set_disp(1, 6'd3, 6'd42, 1);
      step();
      idle_inputs(); delete_tag = 1; step();
      idle_inputs();
      check_val("sq_count", count, 1);
      check_val("sq_tail", dispatch_idx[0], 1);
      set_cdb(0, 6'd41, 32'hDEAD); step();
      idle_inputs(); step();
      check_val("sq_ignored", count, 1);
      set_cdb(0, 6'd40, 32'hA); step();
      idle_inputs(); step();
      check_val("sq_wr0", commit_reg_write[0], 1);
      check_val("sq_wr1", commit_reg_write[1], 0);
      check_val("sq_arn0", commit_arn[0], 1);
      step();

      // Tagged entry waits for clear_tag.
      do_reset();
      set_disp(0, 6'd3, 6'd50, 1); step();
      idle_inputs(); set_cdb(0, 6'd50, 32'h77); step();
      idle_inputs();
      for (int s = 0; s < 4; s++) begin
         step();
         check_val("clr_hold", commit_reg_write[0], 0);
      end
      clear_tag = 1; step();
      idle_inputs(); step();
      check_val("clr_wr0", commit_reg_write[0], 1);
      check_val("clr_res0", commit_result[0], 32'h77);

      // Reset while entries are pending and a matching CDB arrives.
      do_reset();
      set_disp(0, 6'd1, 6'd32, 0); set_disp(1, 6'd2, 6'd33, 0); step();
      set_disp(0, 6'd3, 6'd34, 0); set_disp(1, 6'd4, 6'd35, 0); step();
      idle_inputs(); set_disp(0, 6'd5, 6'd36, 0); step();
      idle_inputs(); reset = 1; set_cdb(0, 6'd32, 32'h5); step();
      check_val("mid_rst_count", count, 0);
      idle_inputs();
      for (int s = 0; s < 3; s++) begin
         step();
         check_val("mid_rst_wr0", commit_reg_write[0], 0);
      end

      // Randomized traffic against the model.
      for (int s = 0; s < 4000; s++) begin
         rand_inputs();
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
